// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {hi = remainder, lo = quotient} through a valid/ack handshake.
module div_iter_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             ack,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned LAST = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a_in;
  logic [WIDTH-1:0] abs_b_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_nx;

  // Operand magnitudes at request time and one restoring-division step.
  always_comb begin
    neg_a    = a[WIDTH-1] & is_signed;
    neg_b    = b[WIDTH-1] & is_signed;
    abs_a_in = neg_a ? WIDTH'(WIDTH'(0) - a) : a;
    abs_b_in = neg_b ? WIDTH'(WIDTH'(0) - b) : b;
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, abs_b};
    qbit     = ~trial[WIDTH];
    rem_nx   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_nx     = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sgn_a     <= 1'b0;
      sgn_b     <= 1'b0;
      abs_b     <= '0;
      rem       <= '0;
      dvd       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      // Cancel anything in flight; the last completed result stays visible.
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn_a    <= neg_a;
            sgn_b    <= neg_b;
            abs_b    <= abs_b_in;
            dvd      <= abs_a_in;
            rem      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (b == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              hi        <= a;
              lo        <= '1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= q_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(LAST)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            lo        <= (sgn_a ^ sgn_b) ? WIDTH'(WIDTH'(0) - q_nx) : q_nx;
            hi        <= sgn_a ? WIDTH'(WIDTH'(0) - rem_nx) : rem_nx;
          end
        end
        DONE: begin
          if (ack) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: scoreboard of expected {hi, lo}
// pushed at request time and popped when out_valid is seen.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, flush, ack;
  logic [31:0] a, b;
  logic        in_ready, busy, out_valid;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .flush(flush), .ack(ack),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
    .hi(hi), .lo(lo)
  );

  // Reference {hi, lo} for a request, from MIPS semantics.
  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF; r = x;
    end else if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = 32'($signed(x) / $signed(y));
        r = 32'($signed(x) % $signed(y));
      end
    end else begin
      q = x / y; r = x % y;
    end
    return {r, q};
  endfunction

  // Issue one request (pushing its expectation) and wait for out_valid.
  // lat is the cycle number out_valid is first seen in, or -1 on timeout.
  task automatic run_div(input logic s, input logic [31:0] x, input logic [31:0] y, output int lat);
    lat = -1;
    sb.push_back(model(s, x, y));
    start = 1'b1; is_signed = s; a = x; b = y;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0; ack = 1'b0;
    a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/busy/vld=%b hi=%h lo=%h, required 100 hi=0 lo=0",
               {in_ready, busy, out_valid}, hi, lo);
    end
  endtask

  task automatic test_divu_basic();
    int lat;
    logic [63:0] e;
    run_div(1'b0, 32'd100, 32'd7, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL divu_latency: got %0d, required 33", lat);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || {hi, lo} !== e) begin
      errors++; $display("FAIL divu_100_7: hi=%0d lo=%0d, required hi=2 lo=14", hi, lo);
    end
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      errors++; $display("FAIL done_flags: rdy/busy=%b, required 01", {in_ready, busy});
    end
    // Result must stay put while waiting for ack, and start must be ignored.
    start = 1'b1; a = 32'd1; b = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {hi, lo} !== e) begin
      errors++; $display("FAIL done_hold: vld=%b hi=%h lo=%h, required 1 hi=%h lo=%h",
                         out_valid, hi, lo, e[63:32], e[31:0]);
    end
    do_ack();
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || {hi, lo} !== e) begin
      errors++; $display("FAIL after_ack: rdy/busy/vld=%b hi=%h lo=%h, required 100 hi=%h lo=%h",
                         {in_ready, busy, out_valid}, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [63:0] e;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || {hi, lo} !== e) begin
      errors++; $display("FAIL div_m7_2: lat=%0d hi=%h lo=%h, required 33 hi=ffffffff lo=fffffffd", lat, hi, lo);
    end
    do_ack();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    e = sb.pop_front();
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1 || {hi, lo} !== e) begin
      errors++; $display("FAIL div_7_m2: hi=%h lo=%h, required hi=1 lo=fffffffd", hi, lo);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    int lat;
    logic [63:0] e;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    e = sb.pop_front();
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || {hi, lo} !== e) begin
      errors++; $display("FAIL div_overflow: hi=%h lo=%h, required hi=0 lo=80000000", hi, lo);
    end
    do_ack();
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    e = sb.pop_front();
    checks++;
    if (lo !== 32'd0 || hi !== 32'h8000_0000 || {hi, lo} !== e) begin
      errors++; $display("FAIL divu_big: hi=%h lo=%h, required hi=80000000 lo=0", hi, lo);
    end
    do_ack();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] e;
    run_div(1'b0, 32'h1234_5678, 32'd0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 1 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678 || {hi, lo} !== e) begin
      errors++; $display("FAIL div_zero: lat=%0d hi=%h lo=%h, required 1 hi=12345678 lo=ffffffff", lat, hi, lo);
    end
    do_ack();
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] e;
    logic [31:0] x, y;
    logic s;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (y == 32'd0) y = 32'd3;
      s = 1'(i % 2);
      run_div(s, x, y, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== 33 || {hi, lo} !== e) begin
        errors++; $display("FAIL random_%0d: s=%b a=%h b=%h lat=%0d hi=%h lo=%h, required 33 hi=%h lo=%h",
                           i, s, x, y, lat, hi, lo, e[63:32], e[31:0]);
      end
      do_ack();
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [63:0] e;
    logic [31:0] ph, pl;
    logic seen;
    ph = hi; pl = lo;
    start = 1'b1; is_signed = 1'b0; a = 32'd5000; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || hi !== ph || lo !== pl) begin
      errors++; $display("FAIL flush_idle: rdy/busy/vld=%b hi=%h lo=%h, required 100 hi=%h lo=%h",
                         {in_ready, busy, out_valid}, hi, lo, ph, pl);
    end
    run_div(1'b1, 32'hFFFF_FF00, 32'd10, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 33 || {hi, lo} !== e) begin
      errors++; $display("FAIL after_flush: lat=%0d hi=%h lo=%h, required 33 hi=%h lo=%h",
                         lat, hi, lo, e[63:32], e[31:0]);
    end
    do_ack();
    // flush together with start drops the request.
    start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || {hi, lo} !== e) begin
      errors++; $display("FAIL flush_with_start: activity=%b hi=%h lo=%h, required 0 hi=%h lo=%h",
                         seen, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_reset_in_done();
    int lat;
    logic [63:0] e;
    logic seen;
    sb.push_back(model(1'b0, 32'd1000, 32'd9));
    start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd77; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      if (out_valid) begin lat = n; break; end
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (lat < 0 || {hi, lo} !== e) begin
      errors++; $display("FAIL start_in_calc: wait=%0d hi=%h lo=%h, required valid hi=%h lo=%h",
                         lat, hi, lo, e[63:32], e[31:0]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_in_done: rdy/busy/vld=%b hi=%h lo=%h, required 100 hi=0 lo=0",
                         {in_ready, busy, out_valid}, hi, lo);
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL no_second_result: valid_seen=%b pending=%0d, required 0 0", seen, sb.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_random();
    test_flush();
    test_reset_in_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
